mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single memory port between the instruction-fetch requester (F stage) and the data requester (M stage) of the 5-stage MIPS pipeline. Requests are serialised through a fixed-latency memory access, and each requester gets a one-cycle completion strobe. Each requester also gets a stall level that freezes its pipeline stage until its access completes. By default, data accesses win over fetches, and a starvation guard bounds how long a fetch can wait.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles `mem_enable` is held per access; must be ≥1.
- STARVE_LIMIT, 4: consecutive fetch losses before fetch is forced to win; must be ≥1.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clock.
- i_req  in  1  fetch request; held until `i_done`.
- i_address  in  32  fetch byte address.
- i_access_size  in  2  fetch access size, passed through to memory.
- d_req  in  1  data request; held until `d_done`.
- d_address  in  32  data byte address.
- d_data_in  in  32  store data.
- d_access_size  in  2  data access size.
- d_rw  in  1  1 = read, 0 = write (memory convention, i.e. ~dmwe).
- i_done, d_done  out  1  one-cycle completion strobe.
- i_rdata, d_rdata  out  32  captured read data; valid while the matching done is high and held afterwards.
- i_stall, d_stall  out  1  combinational: req & ~done.
- mem_address  out  32  to the memory port.
- mem_data_in  out  32  to the memory port.
- mem_access_size  out  2  to the memory port.
- mem_rw  out  1  to the memory port.
- mem_enable  out  1  to the memory port.
- mem_data_out  in  32  from the memory port.

## Operation
States:
- IDLE: arbitrate requests.
- I_ACC: fetch access in progress.
- D_ACC: data access in progress.

Arbitration (IDLE, at posedge):
- Only d_req high: go to D_ACC.
- Only i_req high: go to I_ACC.
- Both high: go to D_ACC, unless `starve_cnt == STARVE_LIMIT`, in which case go to I_ACC.
- Neither high: stay in IDLE.
- On grant, the granted request's address, data, size and rw are latched, and `lat_cnt` is set to MEM_LATENCY-1.

Access (I_ACC / D_ACC):
- `mem_*` outputs drive the latched request and `mem_enable` = 1.
- `lat_cnt` decrements each cycle.
- At the edge where `lat_cnt == 0`: `mem_data_out` is captured into the requester's rdata, the matching done is set for exactly the next cycle, and the state returns to IDLE.
- For fetches, `mem_rw` is always 1.

Starvation counter:
- `starve_cnt` increments, saturating at STARVE_LIMIT, each time a D grant is made while i_req is high.
- It clears on any I grant.

Back-to-back:
- A requester whose req is still high in its done cycle is rearbitrated at the end of that cycle as a new request.
- There is no bubble beyond the IDLE cycle.

Requests that change address mid-access are ignored; the latched values are used.

## Timing
- Reset values (cycle after reset_n sampled low):
  - state = IDLE.
  - lat_cnt, starve_cnt = 0.
  - i_done, d_done = 0.
  - mem_enable = 0.
  - mem_rw = 1.
  - mem_address, mem_data_in = 0; mem_access_size = 0.
  - i_rdata, d_rdata = 0.
- Reset mid-access abandons the access with no done pulse. A partially issued write is the memory's concern.
- Latency: req sampled in IDLE at edge N → done high in cycle N+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+1 cycles.
- Idle output values:
  - mem_enable = 0.
  - mem_address and mem_data_in hold their last values.
- Simultaneous requests in IDLE are resolved by the rules above, with no tie-induced extra cycle.
- starve_cnt has width $clog2(STARVE_LIMIT+1).
- lat_cnt has width $clog2(MEM_LATENCY) (minimum 1).

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: starvation counter and forced fetch grant are present as described.
- Not defined: strict data priority. starve_cnt logic is removed, and fetch wins only when d_req is low.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, I_ACC, D_ACC).
  - requester-ID constants (REQ_I, REQ_D).
  - MEM_RW_READ/MEM_RW_WRITE constants.
- One sub-module, `arb_req_latch`: holds the latched address, data, size and rw of the granted request, with a load strobe and a source select. No other sub-modules.

## Test plan
- Single fetch, MEM_LATENCY=1, i_req at cycle 0, address 0x80020000 → mem_enable high in cycle 1; i_done high in cycle 2; i_rdata = memory word; i_stall low in cycle 2.
- Simultaneous i_req and d_req (read 0x80020010) → D_ACC first, d_done in cycle 2; then I_ACC, i_done in cycle 4; starve_cnt = 1 then 0.
- Data write: d_rw = 0, d_data_in = 0xDEADBEEF at 0x80020020, then fetch of 0x80020020 → mem_rw = 0 during the write, and i_rdata = 0xDEADBEEF.
- Starvation with guard enabled: d_req held high continuously with i_req high, STARVE_LIMIT=4 → 4 data grants, then a fetch grant. Without the guard → no fetch grant while d_req is high.
- MEM_LATENCY=3 → mem_enable high for exactly 3 cycles; done in cycle 4.
- reset_n low during D_ACC cycle 2 of 3 → no d_done; next cycle has state IDLE, mem_enable 0 and all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the F/M memory port arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam logic MEM_RW_READ  = 1'b1;
  localparam logic MEM_RW_WRITE = 1'b0;

endpackage

// File: rtl/arb_req_latch.sv
// Holds the address, store data, size and rw of the granted request so the
// memory port sees stable values for the whole access and afterwards.
module arb_req_latch
  import mem_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        sel,
  input  logic [31:0] i_address,
  input  logic [1:0]  i_access_size,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_in,
  input  logic [1:0]  d_access_size,
  input  logic        d_rw,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic [1:0]  access_size,
  output logic        rw
);

  // Fetches carry no store data, so data keeps whatever the last store left.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      address     <= '0;
      data        <= '0;
      access_size <= '0;
      rw          <= MEM_RW_READ;
    end else if (load) begin
      if (sel == REQ_D) begin
        address     <= d_address;
        data        <= d_data_in;
        access_size <= d_access_size;
        rw          <= d_rw;
      end else begin
        address     <= i_address;
        access_size <= i_access_size;
        rw          <= MEM_RW_READ;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (F) and data (M) requesters.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation; otherwise data has strict priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_address,
  input  logic [1:0]  i_access_size,
  input  logic        d_req,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_in,
  input  logic [1:0]  d_access_size,
  input  logic        d_rw,
  output logic        i_done,
  output logic        d_done,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata,
  output logic        i_stall,
  output logic        d_stall,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic [31:0] mem_data_out
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

  // Handshake: a requester raises req and holds it (with stable operands) until
  // it sees its one-cycle done; req still high in the done cycle is a new request.
  state_t           state, state_next;
  logic [LAT_W-1:0] lat_cnt;
  logic             grant_i, grant_d, last_beat, fetch_forced;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  logic [STARVE_W-1:0] starve_cnt;

  assign fetch_forced = i_req && (starve_cnt == STARVE_MAX);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end
`else
  assign fetch_forced = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    last_beat  = (lat_cnt == '0);
    case (state)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          grant_d    = 1'b1;
          state_next = D_ACC;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = I_ACC;
        end
      end
      I_ACC, D_ACC: begin
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state  <= state_next;
      i_done <= (state == I_ACC) && last_beat;
      d_done <= (state == D_ACC) && last_beat;
      if (grant_i || grant_d) begin
        lat_cnt <= LAT_INIT;
      end else if ((state != IDLE) && !last_beat) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if ((state == I_ACC) && last_beat) i_rdata <= mem_data_out;
      if ((state == D_ACC) && last_beat) d_rdata <= mem_data_out;
    end
  end

  arb_req_latch u_req_latch (
    .clock         (clock),
    .reset_n       (reset_n),
    .load          (grant_i || grant_d),
    .sel           (grant_d ? REQ_D : REQ_I),
    .i_address     (i_address),
    .i_access_size (i_access_size),
    .d_address     (d_address),
    .d_data_in     (d_data_in),
    .d_access_size (d_access_size),
    .d_rw          (d_rw),
    .address       (mem_address),
    .data          (mem_data_in),
    .access_size   (mem_access_size),
    .rw            (mem_rw)
  );

  assign mem_enable = (state == I_ACC) || (state == D_ACC);
  assign i_stall    = i_req & ~i_done;
  assign d_stall    = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1, one at 3,
// each with its own word memory; the idle instance is parked in reset.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n, reset3_n;
  logic        i_req, d_req, d_rw;
  logic [31:0] i_address, d_address, d_data_in;
  logic [1:0]  i_access_size, d_access_size;

  logic        a_i_done, a_d_done, a_i_stall, a_d_stall, a_mem_rw, a_mem_enable;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_address, a_mem_data_in, a_mem_data_out;
  logic [1:0]  a_mem_access_size;
  logic        b_i_done, b_d_done, b_i_stall, b_d_stall, b_mem_rw, b_mem_enable;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_address, b_mem_data_in, b_mem_data_out;
  logic [1:0]  b_mem_access_size;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_address(i_address), .i_access_size(i_access_size),
    .d_req(d_req), .d_address(d_address), .d_data_in(d_data_in),
    .d_access_size(d_access_size), .d_rw(d_rw),
    .i_done(a_i_done), .d_done(a_d_done), .i_rdata(a_i_rdata), .d_rdata(a_d_rdata),
    .i_stall(a_i_stall), .d_stall(a_d_stall),
    .mem_address(a_mem_address), .mem_data_in(a_mem_data_in),
    .mem_access_size(a_mem_access_size), .mem_rw(a_mem_rw),
    .mem_enable(a_mem_enable), .mem_data_out(a_mem_data_out)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clock(clock), .reset_n(reset3_n),
    .i_req(i_req), .i_address(i_address), .i_access_size(i_access_size),
    .d_req(d_req), .d_address(d_address), .d_data_in(d_data_in),
    .d_access_size(d_access_size), .d_rw(d_rw),
    .i_done(b_i_done), .d_done(b_d_done), .i_rdata(b_i_rdata), .d_rdata(b_d_rdata),
    .i_stall(b_i_stall), .d_stall(b_d_stall),
    .mem_address(b_mem_address), .mem_data_in(b_mem_data_in),
    .mem_access_size(b_mem_access_size), .mem_rw(b_mem_rw),
    .mem_enable(b_mem_enable), .mem_data_out(b_mem_data_out)
  );

  function automatic logic [31:0] init_word(int idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // Word memories: combinational read, write on each enabled write cycle.
  initial begin
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = init_word(k);
      mem_b[k] = init_word(k);
    end
  end
  assign a_mem_data_out = mem_a[a_mem_address[9:2]];
  assign b_mem_data_out = mem_b[b_mem_address[9:2]];
  always @(posedge clock) begin
    if (a_mem_enable && (a_mem_rw == MEM_RW_WRITE)) mem_a[a_mem_address[9:2]] <= a_mem_data_in;
    if (b_mem_enable && (b_mem_rw == MEM_RW_WRITE)) mem_b[b_mem_address[9:2]] <= b_mem_data_in;
  end

  task automatic test_reset();
    reset_n = 1'b0; reset3_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_rw = MEM_RW_READ;
    i_address = '0; d_address = '0; d_data_in = '0;
    i_access_size = 2'b10; d_access_size = 2'b10;
    repeat (3) @(negedge clock);
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (dut.lat_cnt !== '0) begin failures++; $display("FAIL reset_lat_cnt got=%0h exp=0", dut.lat_cnt); end
    checks++; if (a_mem_enable !== 1'b0) begin failures++; $display("FAIL reset_mem_enable got=%0b exp=0", a_mem_enable); end
    checks++; if (a_mem_rw !== 1'b1) begin failures++; $display("FAIL reset_mem_rw got=%0b exp=1", a_mem_rw); end
    checks++; if (a_mem_address !== 32'h0) begin failures++; $display("FAIL reset_mem_address got=%0h exp=0", a_mem_address); end
    checks++; if ({a_i_done, a_d_done} !== 2'b00) begin failures++; $display("FAIL reset_done got=%0b exp=00", {a_i_done, a_d_done}); end
    checks++; if ({a_i_rdata, a_d_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", {a_i_rdata, a_d_rdata}); end
`ifdef MEM_ARB_STARVE_GUARD_EN
    checks++; if (dut.starve_cnt !== '0) begin failures++; $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt); end
`endif
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (a_mem_enable !== 1'b0) begin failures++; $display("FAIL idle_mem_enable got=%0b exp=0", a_mem_enable); end
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_address = 32'h8002_0000; i_access_size = 2'b10;
    @(negedge clock);
    checks++; if (a_mem_enable !== 1'b1) begin failures++; $display("FAIL fetch_enable got=%0b exp=1", a_mem_enable); end
    checks++; if (a_mem_address !== 32'h8002_0000) begin failures++; $display("FAIL fetch_address got=%0h exp=80020000", a_mem_address); end
    checks++; if (a_mem_rw !== 1'b1) begin failures++; $display("FAIL fetch_rw got=%0b exp=1", a_mem_rw); end
    checks++; if (a_mem_access_size !== 2'b10) begin failures++; $display("FAIL fetch_size got=%0b exp=10", a_mem_access_size); end
    checks++; if ({a_i_stall, a_i_done} !== 2'b10) begin failures++; $display("FAIL fetch_stall_c1 got=%0b exp=10", {a_i_stall, a_i_done}); end
    i_address = 32'h8002_0100;
    @(negedge clock);
    checks++; if (a_i_done !== 1'b1) begin failures++; $display("FAIL fetch_done got=%0b exp=1", a_i_done); end
    checks++; if (a_i_rdata !== init_word(0)) begin failures++; $display("FAIL fetch_rdata got=%0h exp=%0h", a_i_rdata, init_word(0)); end
    checks++; if (a_i_stall !== 1'b0) begin failures++; $display("FAIL fetch_stall_c2 got=%0b exp=0", a_i_stall); end
    checks++; if (a_mem_enable !== 1'b0) begin failures++; $display("FAIL fetch_enable_c2 got=%0b exp=0", a_mem_enable); end
    checks++; if (a_mem_address !== 32'h8002_0000) begin failures++; $display("FAIL fetch_addr_hold got=%0h exp=80020000", a_mem_address); end
    i_req = 1'b0;
    @(negedge clock);
    checks++; if (a_i_done !== 1'b0) begin failures++; $display("FAIL fetch_done_c3 got=%0b exp=0", a_i_done); end
    checks++; if (a_i_rdata !== init_word(0)) begin failures++; $display("FAIL fetch_rdata_hold got=%0h exp=%0h", a_i_rdata, init_word(0)); end
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; i_address = 32'h8002_0004;
    d_req = 1'b1; d_address = 32'h8002_0010; d_rw = MEM_RW_READ;
    @(negedge clock);
    checks++; if (a_mem_address !== 32'h8002_0010) begin failures++; $display("FAIL sim_d_first got=%0h exp=80020010", a_mem_address); end
    checks++; if ({a_i_stall, a_d_stall} !== 2'b11) begin failures++; $display("FAIL sim_stalls_c1 got=%0b exp=11", {a_i_stall, a_d_stall}); end
`ifdef MEM_ARB_STARVE_GUARD_EN
    checks++; if (dut.starve_cnt !== 3'd1) begin failures++; $display("FAIL sim_starve_1 got=%0d exp=1", dut.starve_cnt); end
`endif
    @(negedge clock);
    checks++; if ({a_d_done, a_i_done} !== 2'b10) begin failures++; $display("FAIL sim_d_done got=%0b exp=10", {a_d_done, a_i_done}); end
    checks++; if (a_d_rdata !== init_word(4)) begin failures++; $display("FAIL sim_d_rdata got=%0h exp=%0h", a_d_rdata, init_word(4)); end
    checks++; if ({a_i_stall, a_d_stall} !== 2'b10) begin failures++; $display("FAIL sim_stalls_c2 got=%0b exp=10", {a_i_stall, a_d_stall}); end
    d_req = 1'b0;
    @(negedge clock);
    checks++; if ({a_mem_enable, a_mem_address} !== {1'b1, 32'h8002_0004}) begin failures++; $display("FAIL sim_i_access got=%0h exp=180020004", {a_mem_enable, a_mem_address}); end
`ifdef MEM_ARB_STARVE_GUARD_EN
    checks++; if (dut.starve_cnt !== 3'd0) begin failures++; $display("FAIL sim_starve_0 got=%0d exp=0", dut.starve_cnt); end
`endif
    @(negedge clock);
    checks++; if (a_i_done !== 1'b1) begin failures++; $display("FAIL sim_i_done got=%0b exp=1", a_i_done); end
    checks++; if (a_i_rdata !== init_word(1)) begin failures++; $display("FAIL sim_i_rdata got=%0h exp=%0h", a_i_rdata, init_word(1)); end
    i_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_data_write();
    d_req = 1'b1; d_rw = MEM_RW_WRITE; d_data_in = 32'hDEAD_BEEF;
    d_address = 32'h8002_0020; d_access_size = 2'b01;
    @(negedge clock);
    checks++; if ({a_mem_enable, a_mem_rw} !== 2'b10) begin failures++; $display("FAIL wr_enable_rw got=%0b exp=10", {a_mem_enable, a_mem_rw}); end
    checks++; if (a_mem_data_in !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_data got=%0h exp=deadbeef", a_mem_data_in); end
    checks++; if (a_mem_access_size !== 2'b01) begin failures++; $display("FAIL wr_size got=%0b exp=01", a_mem_access_size); end
    @(negedge clock);
    checks++; if (a_d_done !== 1'b1) begin failures++; $display("FAIL wr_done got=%0b exp=1", a_d_done); end
    d_req = 1'b0; d_rw = MEM_RW_READ; d_access_size = 2'b10;
    i_req = 1'b1; i_address = 32'h8002_0020;
    @(negedge clock);
    checks++; if (a_mem_rw !== 1'b1) begin failures++; $display("FAIL wr_fetch_rw got=%0b exp=1", a_mem_rw); end
    checks++; if (a_mem_data_in !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_data_hold got=%0h exp=deadbeef", a_mem_data_in); end
    @(negedge clock);
    checks++; if ({a_i_done, a_i_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wr_readback got=%0h exp=1deadbeef", {a_i_done, a_i_rdata}); end
    i_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    i_req = 1'b1; i_address = 32'h8002_0008;
    @(negedge clock);
    checks++; if (a_mem_enable !== 1'b1) begin failures++; $display("FAIL b2b_enable1 got=%0b exp=1", a_mem_enable); end
    @(negedge clock);
    checks++; if ({a_i_done, a_i_rdata} !== {1'b1, init_word(2)}) begin failures++; $display("FAIL b2b_done1 got=%0h exp=%0h", {a_i_done, a_i_rdata}, {1'b1, init_word(2)}); end
    i_address = 32'h8002_000C;
    @(negedge clock);
    checks++; if ({a_mem_enable, a_i_done, a_mem_address} !== {2'b10, 32'h8002_000C}) begin failures++; $display("FAIL b2b_regrant got=%0h exp=28002000c", {a_mem_enable, a_i_done, a_mem_address}); end
    @(negedge clock);
    checks++; if ({a_i_done, a_i_rdata} !== {1'b1, init_word(3)}) begin failures++; $display("FAIL b2b_done2 got=%0h exp=%0h", {a_i_done, a_i_rdata}, {1'b1, init_word(3)}); end
    i_req = 1'b0;
    @(negedge clock);
    checks++; if ({a_mem_enable, a_i_done} !== 2'b00) begin failures++; $display("FAIL b2b_quiet got=%0b exp=00", {a_mem_enable, a_i_done}); end
  endtask

  task automatic test_starvation();
    int n_d = 0;
    int n_i = 0;
    i_req = 1'b1; i_address = 32'h8002_0000;
    d_req = 1'b1; d_address = 32'h8002_0010; d_rw = MEM_RW_READ;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 20 && n_i == 0; c++) begin
      @(negedge clock);
      if (a_i_done) begin n_i++; i_req = 1'b0; d_req = 1'b0; end
      else if (a_d_done) n_d++;
    end
    checks++; if (n_i !== 1) begin failures++; $display("FAIL starve_fetch_grant got=%0d exp=1", n_i); end
    checks++; if (n_d !== 4) begin failures++; $display("FAIL starve_d_grants got=%0d exp=4", n_d); end
`else
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (a_i_done) n_i++;
      if (a_d_done) n_d++;
    end
    d_req = 1'b0;
    checks++; if (n_i !== 0) begin failures++; $display("FAIL strict_no_fetch got=%0d exp=0", n_i); end
    checks++; if (n_d !== 8) begin failures++; $display("FAIL strict_d_grants got=%0d exp=8", n_d); end
    for (int c = 0; c < 6 && n_i == 0; c++) begin
      @(negedge clock);
      if (a_i_done) begin n_i++; i_req = 1'b0; end
    end
    checks++; if (n_i !== 1) begin failures++; $display("FAIL strict_fetch_after got=%0d exp=1", n_i); end
`endif
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_latency3();
    reset_n = 1'b0; reset3_n = 1'b1;
    @(negedge clock);
    d_req = 1'b1; d_rw = MEM_RW_READ; d_address = 32'h8002_0030;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      checks++; if ({b_mem_enable, b_d_done} !== 2'b10) begin failures++; $display("FAIL lat3_enable_c%0d got=%0b exp=10", c, {b_mem_enable, b_d_done}); end
    end
    @(negedge clock);
    checks++; if ({b_mem_enable, b_d_done} !== 2'b01) begin failures++; $display("FAIL lat3_done got=%0b exp=01", {b_mem_enable, b_d_done}); end
    checks++; if (b_d_rdata !== init_word(12)) begin failures++; $display("FAIL lat3_rdata got=%0h exp=%0h", b_d_rdata, init_word(12)); end
    d_req = 1'b0;
    @(negedge clock);
    checks++; if (b_d_done !== 1'b0) begin failures++; $display("FAIL lat3_done_c5 got=%0b exp=0", b_d_done); end
  endtask

  task automatic test_reset_mid_access();
    d_req = 1'b1; d_rw = MEM_RW_WRITE; d_data_in = 32'h1234_5678; d_address = 32'h8002_0040;
    @(negedge clock);
    checks++; if ({b_mem_enable, b_mem_rw} !== 2'b10) begin failures++; $display("FAIL rst_mid_c1 got=%0b exp=10", {b_mem_enable, b_mem_rw}); end
    @(negedge clock);
    reset3_n = 1'b0; d_req = 1'b0; d_rw = MEM_RW_READ;
    @(negedge clock);
    checks++; if (b_d_done !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%0b exp=0", b_d_done); end
    checks++; if (dut3.state !== IDLE) begin failures++; $display("FAIL rst_mid_state got=%0d exp=%0d", dut3.state, IDLE); end
    checks++; if ({b_mem_enable, b_mem_rw, b_mem_access_size} !== 4'b0100) begin failures++; $display("FAIL rst_mid_ctrl got=%0b exp=0100", {b_mem_enable, b_mem_rw, b_mem_access_size}); end
    checks++; if ({b_mem_address, b_mem_data_in} !== 64'h0) begin failures++; $display("FAIL rst_mid_addr_data got=%0h exp=0", {b_mem_address, b_mem_data_in}); end
    checks++; if ({b_i_rdata, b_d_rdata} !== 64'h0) begin failures++; $display("FAIL rst_mid_rdata got=%0h exp=0", {b_i_rdata, b_d_rdata}); end
    checks++; if (dut3.lat_cnt !== '0) begin failures++; $display("FAIL rst_mid_lat_cnt got=%0d exp=0", dut3.lat_cnt); end
    reset3_n = 1'b1;
    @(negedge clock);
    checks++; if ({b_mem_enable, b_d_done} !== 2'b00) begin failures++; $display("FAIL rst_mid_after got=%0b exp=00", {b_mem_enable, b_d_done}); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_data_write();
    test_back_to_back();
    test_starvation();
    test_latency3();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
